// File: rtl/instr_ctrl_axilite_slave.sv
// AXI4-Lite control/status register file for the instrumentation wrapper.
// One RW control register (gen/sink enables, LFSR seed) and five read-only status words.
module instr_ctrl_axilite_slave #(
   parameter int          ADDR_WIDTH  = 32,
   parameter logic [1:0]  RESP_SLVERR = 2'b10
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [ADDR_WIDTH-1:0] s_axi_ctrl_awaddr,
   input  logic                  s_axi_ctrl_awvalid,
   output logic                  s_axi_ctrl_awready,
   input  logic [31:0]           s_axi_ctrl_wdata,
   input  logic [3:0]            s_axi_ctrl_wstrb,
   input  logic                  s_axi_ctrl_wvalid,
   output logic                  s_axi_ctrl_wready,
   output logic [1:0]            s_axi_ctrl_bresp,
   output logic                  s_axi_ctrl_bvalid,
   input  logic                  s_axi_ctrl_bready,
   input  logic [ADDR_WIDTH-1:0] s_axi_ctrl_araddr,
   input  logic                  s_axi_ctrl_arvalid,
   output logic                  s_axi_ctrl_arready,
   output logic [31:0]           s_axi_ctrl_rdata,
   output logic [1:0]            s_axi_ctrl_rresp,
   output logic                  s_axi_ctrl_rvalid,
   input  logic                  s_axi_ctrl_rready,
   output logic                  gen_en,
   output logic                  sink_en,
   output logic [15:0]           lfsr_seed,
   output logic                  gen_start,
   input  logic [31:0]           status_i,
   input  logic [31:0]           status_o,
   input  logic [31:0]           latency,
   input  logic [31:0]           interval,
   input  logic [31:0]           checksum
);

   localparam logic [5:0] A_CTRL = 6'h04;
   localparam logic [5:0] A_STI  = 6'h06;
   localparam logic [5:0] A_STO  = 6'h08;
   localparam logic [5:0] A_LAT  = 6'h0A;
   localparam logic [5:0] A_INT  = 6'h0E;
   localparam logic [5:0] A_CHK  = 6'h12;
   localparam logic [1:0] RESP_OKAY = 2'b00;

   logic        init_q;
   logic        aw_held_q, w_held_q;
   logic [5:0]  aw_idx_q;
   logic [31:0] w_data_q;
   logic [3:0]  w_strb_q;
   logic        bvalid_q, rvalid_q;
   logic [1:0]  bresp_q, rresp_q;
   logic [31:0] rdata_q;
   logic        gen_q, sink_q, gen_start_q;
   logic [15:0] seed_q;

   logic        aw_hs, w_hs, ar_hs, commit, wr_mapped;
   logic [5:0]  ar_idx;
   logic [31:0] ctrl_cur, ctrl_d, rd_data_d;
   logic [1:0]  rd_resp_d;
   logic        unused_ok;

   // init_q keeps every ready low while reset is asserted and for the first edge after release
   assign s_axi_ctrl_awready = init_q & ~aw_held_q & ~bvalid_q;
   assign s_axi_ctrl_wready  = init_q & ~w_held_q & ~bvalid_q;
   assign s_axi_ctrl_arready = init_q & ~rvalid_q;
   assign s_axi_ctrl_bvalid  = bvalid_q;
   assign s_axi_ctrl_bresp   = bresp_q;
   assign s_axi_ctrl_rvalid  = rvalid_q;
   assign s_axi_ctrl_rdata   = rdata_q;
   assign s_axi_ctrl_rresp   = rresp_q;
   assign gen_en    = gen_q;
   assign sink_en   = sink_q;
   assign lfsr_seed = seed_q;
   assign gen_start = gen_start_q;

   assign aw_hs  = s_axi_ctrl_awvalid & s_axi_ctrl_awready;
   assign w_hs   = s_axi_ctrl_wvalid & s_axi_ctrl_wready;
   assign ar_hs  = s_axi_ctrl_arvalid & s_axi_ctrl_arready;
   assign commit = aw_held_q & w_held_q;
   assign ar_idx = s_axi_ctrl_araddr[7:2];

   assign ctrl_cur = {seed_q, 14'b0, sink_q, gen_q};

   always_comb begin
      ctrl_d = ctrl_cur;
      for (int b = 0; b < 4; b++) begin
         if (w_strb_q[b]) ctrl_d[8*b +: 8] = w_data_q[8*b +: 8];
      end
   end

   always_comb begin
      wr_mapped = 1'b0;
      case (aw_idx_q)
         A_CTRL, A_STI, A_STO, A_LAT, A_INT, A_CHK: wr_mapped = 1'b1;
         default:                                   wr_mapped = 1'b0;
      endcase
   end

   always_comb begin
      rd_data_d = 32'h0;
      rd_resp_d = RESP_OKAY;
      case (ar_idx)
         A_CTRL:  rd_data_d = ctrl_cur;
         A_STI:   rd_data_d = status_i;
         A_STO:   rd_data_d = status_o;
         A_LAT:   rd_data_d = latency;
         A_INT:   rd_data_d = interval;
         A_CHK:   rd_data_d = checksum;
         default: rd_resp_d = RESP_SLVERR;
      endcase
   end

   assign unused_ok = ^{s_axi_ctrl_awaddr[ADDR_WIDTH-1:8], s_axi_ctrl_awaddr[1:0],
                        s_axi_ctrl_araddr[ADDR_WIDTH-1:8], s_axi_ctrl_araddr[1:0], ctrl_d[15:2]};

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         init_q      <= 1'b0;
         aw_held_q   <= 1'b0;
         w_held_q    <= 1'b0;
         aw_idx_q    <= 6'h0;
         w_data_q    <= 32'h0;
         w_strb_q    <= 4'h0;
         bvalid_q    <= 1'b0;
         bresp_q     <= 2'b00;
         rvalid_q    <= 1'b0;
         rdata_q     <= 32'h0;
         rresp_q     <= 2'b00;
         gen_q       <= 1'b0;
         sink_q      <= 1'b0;
         seed_q      <= 16'h0;
         gen_start_q <= 1'b0;
      end else begin
         init_q      <= 1'b1;
         gen_start_q <= 1'b0;
         if (aw_hs) begin
            aw_held_q <= 1'b1;
            aw_idx_q  <= s_axi_ctrl_awaddr[7:2];
         end
         if (w_hs) begin
            w_held_q <= 1'b1;
            w_data_q <= s_axi_ctrl_wdata;
            w_strb_q <= s_axi_ctrl_wstrb;
         end
         if (commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            if (aw_idx_q == A_CTRL) begin
               gen_q       <= ctrl_d[0];
               sink_q      <= ctrl_d[1];
               seed_q      <= ctrl_d[31:16];
               gen_start_q <= ~gen_q & ctrl_d[0];
            end
         end else if (bvalid_q && s_axi_ctrl_bready) begin
            bvalid_q <= 1'b0;
         end
         // read data comes from pre-edge CTRL, so a same-edge CTRL commit returns the old value
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_d;
            rresp_q  <= rd_resp_d;
         end else if (rvalid_q && s_axi_ctrl_rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_ctrl_axilite_slave.sv
// Scoreboard bench for instr_ctrl_axilite_slave: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them at each handshake.
module tb_instr_ctrl_axilite_slave;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [3:0]  wstrb = '0;
   logic [1:0]  bresp, rresp;
   logic        gen_en, sink_en, gen_start;
   logic [15:0] lfsr_seed;
   logic [31:0] status_i = 32'd7, status_o = 32'h55, latency = 32'd123;
   logic [31:0] interval = 32'd9, checksum = 32'h2F00_00AB;

   int n_chk = 0;
   int n_fail = 0;
   int gs_cnt = 0;
   logic gs_prev = 1'b0;
   logic [1:0]  bq[$];
   logic [33:0] rq[$];

   always #5 ap_clk = ~ap_clk;

   instr_ctrl_axilite_slave #(.ADDR_WIDTH(32), .RESP_SLVERR(2'b10)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .s_axi_ctrl_awaddr(awaddr), .s_axi_ctrl_awvalid(awvalid), .s_axi_ctrl_awready(awready),
      .s_axi_ctrl_wdata(wdata), .s_axi_ctrl_wstrb(wstrb), .s_axi_ctrl_wvalid(wvalid),
      .s_axi_ctrl_wready(wready), .s_axi_ctrl_bresp(bresp), .s_axi_ctrl_bvalid(bvalid),
      .s_axi_ctrl_bready(bready), .s_axi_ctrl_araddr(araddr), .s_axi_ctrl_arvalid(arvalid),
      .s_axi_ctrl_arready(arready), .s_axi_ctrl_rdata(rdata), .s_axi_ctrl_rresp(rresp),
      .s_axi_ctrl_rvalid(rvalid), .s_axi_ctrl_rready(rready),
      .gen_en(gen_en), .sink_en(sink_en), .lfsr_seed(lfsr_seed), .gen_start(gen_start),
      .status_i(status_i), .status_o(status_o), .latency(latency), .interval(interval),
      .checksum(checksum)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: compare at the negedge preceding each handshake edge
   always @(negedge ap_clk) begin
      if (ap_rst_n) begin
         if (bvalid && bready) begin
            if (bq.size() == 0) chk("unexpected_b", 64'(bresp), 64'hDEAD);
            else chk("bresp", 64'(bresp), 64'(bq.pop_front()));
         end
         if (rvalid && rready) begin
            if (rq.size() == 0) chk("unexpected_r", 64'({rdata, rresp}), 64'hDEAD);
            else chk("rdata_rresp", 64'({rdata, rresp}), 64'(rq.pop_front()));
         end
         if (gen_start) begin
            gs_cnt++;
            if (gs_prev) chk("gen_start_single_cycle", 64'(gen_start), 64'h0);
         end
      end
      gs_prev = gen_start;
   end

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_at, input int w_at, input int b_dly,
                            input logic [1:0] exp, output int b_lat);
      bit aw_done, w_done, done, aw_hs, w_hs, b_hs;
      int b_seen, last_hs, first_b;
      logic [1:0] b0;
      aw_done = 0; w_done = 0; done = 0; b_seen = 0; last_hs = 0; first_b = 0; b0 = '0;
      bq.push_back(exp);
      for (int c = 0; !done && c < 60; c++) begin
         if (!aw_done && c == aw_at) begin awaddr = addr; awvalid = 1'b1; end
         if (!w_done && c == w_at) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
         bready = (b_seen >= b_dly);
         @(negedge ap_clk);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         b_hs  = bvalid && bready;
         if (aw_hs || w_hs) last_hs = c;
         if (aw_done) chk("awready_low_while_held", 64'(awready), 64'h0);
         if (w_done)  chk("wready_low_while_held", 64'(wready), 64'h0);
         if (bvalid) begin
            if (b_seen == 0) begin first_b = c; b0 = bresp; end
            else chk("bresp_stable", 64'(bresp), 64'(b0));
            b_seen++;
         end else if (b_seen != 0) chk("bvalid_held", 64'(bvalid), 64'h1);
         @(posedge ap_clk); #1;
         if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
         if (w_hs)  begin wvalid = 1'b0; w_done = 1; end
         if (b_hs) done = 1;
      end
      if (!done) chk("write_timeout", 64'h0, 64'h1);
      bready = 1'b0;
      b_lat = first_b - last_hs;
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r,
                           input int r_dly);
      bit ar_hs, r_hs, done;
      int rv_cnt, ar_c;
      logic [33:0] r0;
      ar_hs = 0; done = 0; rv_cnt = 0; ar_c = -10; r0 = '0;
      rq.push_back({exp_d, exp_r});
      araddr = addr; arvalid = 1'b1;
      for (int c = 0; !done && c < 60; c++) begin
         rready = (rv_cnt >= r_dly);
         @(negedge ap_clk);
         ar_hs = arvalid && arready;
         r_hs  = rvalid && rready;
         if (ar_hs) ar_c = c;
         if (rvalid) begin
            if (rv_cnt == 0) begin
               r0 = {rdata, rresp};
               chk("read_latency", 64'(c - ar_c), 64'h1);
            end else chk("r_stable", 64'({rdata, rresp}), 64'(r0));
            rv_cnt++;
         end
         @(posedge ap_clk); #1;
         if (ar_hs) arvalid = 1'b0;
         if (r_hs) done = 1;
      end
      if (!done) chk("read_timeout", 64'h0, 64'h1);
      rready = 1'b0;
   endtask

   initial begin
      int lat, g0;
      bit seen;
      #12;
      chk("reset_outputs", 64'({awready, wready, bvalid, arready, rvalid, rdata, bresp, rresp,
                                gen_en, sink_en, lfsr_seed, gen_start}), 64'h0);
      @(negedge ap_clk); ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      chk("ctrl_after_reset", 64'({gen_en, sink_en, lfsr_seed}), 64'h0);
      axi_read(32'h10, 32'h0, 2'b00, 0);

      g0 = gs_cnt;
      axi_write(32'h10, 32'h0001_0003, 4'hF, 0, 0, 0, 2'b00, lat);
      chk("b_after_commit_same_cycle", 64'(lat), 64'd2);
      chk("ctrl_fields_a", 64'({gen_en, sink_en, lfsr_seed}), 64'({1'b1, 1'b1, 16'h0001}));
      repeat (2) @(posedge ap_clk); #1;
      chk("gen_start_pulse_count", 64'(gs_cnt - g0), 64'd1);
      axi_read(32'h10, 32'h0001_0003, 2'b00, 0);

      g0 = gs_cnt;
      axi_write(32'h10, 32'h0001_0003, 4'hF, 3, 0, 5, 2'b00, lat);
      chk("b_after_commit_w_first", 64'(lat), 64'd2);
      repeat (2) @(posedge ap_clk); #1;
      chk("no_gen_start_1_over_1", 64'(gs_cnt - g0), 64'd0);

      axi_read(32'h18, 32'd7, 2'b00, 2);
      axi_read(32'h20, 32'h55, 2'b00, 0);
      axi_read(32'h28, 32'd123, 2'b00, 2);
      axi_read(32'h38, 32'd9, 2'b00, 0);
      axi_read(32'hFFFF_FF48, 32'h2F00_00AB, 2'b00, 2);

      axi_read(32'h40, 32'h0, 2'b10, 1);
      axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, 0, 1, 0, 2'b10, lat);
      axi_write(32'h18, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 2'b00, lat);
      axi_read(32'h10, 32'h0001_0003, 2'b00, 0);
      axi_read(32'h18, 32'd7, 2'b00, 0);

      axi_write(32'h10, 32'h0000_FFFF, 4'hF, 0, 0, 0, 2'b00, lat);
      axi_read(32'h10, 32'h0000_0003, 2'b00, 0);
      g0 = gs_cnt;
      axi_write(32'h10, 32'hFFFF_0000, 4'b1100, 0, 0, 1, 2'b00, lat);
      axi_read(32'h10, 32'hFFFF_0003, 2'b00, 0);
      chk("no_gen_start_strobed", 64'(gs_cnt - g0), 64'd0);

      // reset while bvalid is pending: no B expected
      awaddr = 32'h10; wdata = 32'h1234_0000; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      @(negedge ap_clk);
      chk("aw_w_accept_for_reset", 64'({awready, wready}), 64'h3);
      @(posedge ap_clk); #1; awvalid = 1'b0; wvalid = 1'b0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge ap_clk);
         if (bvalid) seen = 1;
      end
      chk("bvalid_before_reset", 64'(seen), 64'h1);
      chk("ctrl_committed_before_reset", 64'(lfsr_seed), 64'h1234);
      #2 ap_rst_n = 1'b0;
      #1;
      chk("reset_mid_b", 64'({bvalid, gen_en, sink_en, lfsr_seed}), 64'h0);
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk); ap_rst_n = 1'b1;
      repeat (2) @(posedge ap_clk); #1;
      chk("b_queue_drained", 64'(bq.size()), 64'h0);
      chk("r_queue_drained", 64'(rq.size()), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, n_chk=%0d", n_chk);
      $fatal(1, "timeout");
   end

endmodule
